cache_way_ctrl: RTL and testbench
=================================

Name: cache_way_ctrl

Overview:
- Control FSM for the 8-way set-associative cache, sitting directly downstream of the pLRU tree.
- Consumes the tree's `plru` victim way and the datapath's per-way hit/valid/dirty vectors, and drives the data/tag array loads and physical-memory handshake.
- Feeds the tree's update port (`load`, `index`, `last_access`) on every completed access.
- Keeps saturating hit/miss counters for performance reporting.

Parameters:
- s_index, 3, set-index width; must match the pLRU tree instance.
- s_cnt, 32, width of the hit and miss counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- index  in  s_index  set index of the current CPU address
- hit_vec  in  8  per-way tag match AND valid, from the datapath
- valid_vec  in  8  valid bits of the indexed set
- dirty_vec  in  8  dirty bits of the indexed set
- plru  in  3  pLRU victim way from the tree
- pmem_resp  in  1  physical-memory completion pulse
- mem_resp  out  1  CPU access complete
- way_sel  out  3  way addressed by the data/tag arrays this cycle
- load_data  out  8  one-hot data-array write enable
- load_tag  out  8  one-hot tag/valid write enable
- data_src  out  1  0 = CPU write data, 1 = pmem line
- set_dirty  out  1  set the dirty bit of way_sel
- clr_dirty  out  1  clear the dirty bit of way_sel
- pmem_read  out  1  line fill request
- pmem_write  out  1  writeback request
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag address
- plru_load  out  1  pLRU tree update strobe
- plru_index  out  s_index  set index for the tree update (= index)
- plru_last_access  out  3  way accessed, for the tree update
- hit_count  out  s_cnt  saturating hit counter
- miss_count  out  s_cnt  saturating miss counter

Behaviour:
- FSM states: CHECK, WB, FILL. Reset state is CHECK.
- Reset values: all outputs 0, victim register 0, both counters 0.
- rst mid-operation: returns to CHECK next cycle; pmem_read/pmem_write drop that cycle; no array or tree update is issued.
- Default outputs, in any state unless overridden below: 0. plru_index always = index.
- Hit way: lowest-index set bit of hit_vec (multiple-hit tie-break).

CHECK:
- No request: idle, no outputs.
- Request with hit_vec != 0, same cycle, combinational:
  - mem_resp=1, way_sel=hit way
  - plru_load=1, plru_last_access=hit way
  - hit_count increments at the clock edge
- Write hit, additionally: load_data[hit way]=1, data_src=0, set_dirty=1.
- Request with hit_vec == 0 (miss):
  - Victim = lowest-index invalid way if valid_vec != 8'hFF, else plru.
  - Victim is registered at the clock edge; miss_count increments.
  - Next state is WB if the victim is valid and dirty, else FILL.
  - mem_resp=0.
- mem_read and mem_write both high: treated as a write.

WB:
- pmem_write=1, pmem_addr_sel=1, way_sel=victim.
- Hold until pmem_resp, then go to FILL.

FILL:
- pmem_read=1, pmem_addr_sel=0, way_sel=victim.
- On pmem_resp, same cycle: load_data[victim]=1, load_tag[victim]=1, data_src=1, clr_dirty=1; then go to CHECK.
- The re-check then hits, responds, and updates the tree. The tree is never updated in WB or FILL.

Other rules:
- pmem_resp in CHECK is ignored.
- pmem_read and pmem_write are never high together.
- Counters saturate at all-ones; no wrap.
- Latency:
  - hit: mem_resp in the request cycle
  - clean miss: mem_resp 1 cycle after pmem_resp
  - dirty miss: two pmem transactions, then 1 cycle

Test Plan:
- Read, index=2, hit_vec=8'h20 -> same cycle mem_resp=1, way_sel=5, plru_load=1, plru_last_access=5, hit_count=1, no pmem activity.
- Write, hit_vec=8'h04 -> load_data=8'h04, set_dirty=1, data_src=0, mem_resp=1.
- Read miss, valid_vec=8'hF7, plru=6 -> victim 3, FILL entered, pmem_read=1 until pmem_resp (sent after 5 cycles), then load_data=load_tag=8'h08, clr_dirty=1; next cycle with hit_vec=8'h08, mem_resp=1; miss_count=1.
- Read miss, valid_vec=8'hFF, dirty_vec=8'h40, plru=6 -> WB with pmem_write=1, pmem_addr_sel=1, way_sel=6; after pmem_resp, FILL with pmem_read=1; after pmem_resp, load_data=8'h40.
- rst asserted during WB with pmem_write high -> next cycle state CHECK, pmem_write=0, counters=0, no load_data/load_tag pulse.
- Force hit_count to all-ones, then one more hit -> count stays all-ones; hit_vec=8'h22 -> way_sel=1.

Source files
------------

// File: rtl/cache_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_way_ctrl
// Brief   : Control FSM for the 8-way set-associative cache. Resolves hits,
//           selects victims and sequences writeback/fill against physical
//           memory. Also drives the pLRU tree update port and keeps
//           saturating hit/miss counters.
// Revision: 1.0 - initial release
// ============================================================================
module cache_way_ctrl #(
  parameter int s_index = 3,
  parameter int s_cnt   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [s_index-1:0] index,
  input  logic [7:0]         hit_vec,
  input  logic [7:0]         valid_vec,
  input  logic [7:0]         dirty_vec,
  input  logic [2:0]         plru,
  input  logic               pmem_resp,
  output logic               mem_resp,
  output logic [2:0]         way_sel,
  output logic [7:0]         load_data,
  output logic [7:0]         load_tag,
  output logic               data_src,
  output logic               set_dirty,
  output logic               clr_dirty,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
  output logic               plru_load,
  output logic [s_index-1:0] plru_index,
  output logic [2:0]         plru_last_access,
  output logic [s_cnt-1:0]   hit_count,
  output logic [s_cnt-1:0]   miss_count
);

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2
  } state_t;

  localparam logic [s_cnt-1:0] c_cnt_max = '1;

  state_t           r_state;
  logic [2:0]       r_victim;
  logic [s_cnt-1:0] r_hit_count;
  logic [s_cnt-1:0] r_miss_count;

  logic       w_req;
  logic       w_hit;
  logic [2:0] w_hit_way;
  logic [2:0] w_inv_way;
  logic [2:0] w_victim;
  logic       w_victim_dirty;

  assign w_req = mem_read | mem_write;
  assign w_hit = |hit_vec;

  // Scan from the top down so the lowest-index set bit wins.
  always_comb begin
    w_hit_way = 3'd0;
    w_inv_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit_vec[i])    w_hit_way = 3'(i);
      if (!valid_vec[i]) w_inv_way = 3'(i);
    end
  end

  assign w_victim       = (valid_vec != 8'hFF) ? w_inv_way : plru;
  assign w_victim_dirty = valid_vec[w_victim] & dirty_vec[w_victim];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= CHECK;
      r_victim     <= 3'd0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        CHECK: begin
          if (w_req) begin
            if (w_hit) begin
              if (r_hit_count != c_cnt_max) r_hit_count <= r_hit_count + s_cnt'(1);
            end else begin
              r_victim <= w_victim;
              if (r_miss_count != c_cnt_max) r_miss_count <= r_miss_count + s_cnt'(1);
              r_state <= w_victim_dirty ? WB : FILL;
            end
          end
        end
        WB:      if (pmem_resp) r_state <= FILL;
        FILL:    if (pmem_resp) r_state <= CHECK;
        default: r_state <= CHECK;
      endcase
    end
  end

  // Outputs are held low while rst is high so an in-flight access issues nothing.
  always_comb begin
    mem_resp         = 1'b0;
    way_sel          = 3'd0;
    load_data        = 8'h00;
    load_tag         = 8'h00;
    data_src         = 1'b0;
    set_dirty        = 1'b0;
    clr_dirty        = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_addr_sel    = 1'b0;
    plru_load        = 1'b0;
    plru_last_access = 3'd0;
    if (!rst) begin
      case (r_state)
        CHECK: begin
          if (w_req && w_hit) begin
            mem_resp         = 1'b1;
            way_sel          = w_hit_way;
            plru_load        = 1'b1;
            plru_last_access = w_hit_way;
            if (mem_write) begin
              load_data = 8'b1 << w_hit_way;
              data_src  = 1'b0;
              set_dirty = 1'b1;
            end
          end
        end
        WB: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = r_victim;
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = r_victim;
          if (pmem_resp) begin
            load_data = 8'b1 << r_victim;
            load_tag  = 8'b1 << r_victim;
            data_src  = 1'b1;
            clr_dirty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign plru_index = index;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_way_ctrl
// Brief   : Directed bench for cache_way_ctrl with a response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_way_ctrl;

  localparam int c_si = 3;
  localparam int c_sc = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_read, mem_write;
  logic [c_si-1:0] index;
  logic [7:0]      hit_vec, valid_vec, dirty_vec;
  logic [2:0]      plru;
  logic            pmem_resp;
  logic            mem_resp;
  logic [2:0]      way_sel;
  logic [7:0]      load_data, load_tag;
  logic            data_src, set_dirty, clr_dirty;
  logic            pmem_read, pmem_write, pmem_addr_sel;
  logic            plru_load;
  logic [c_si-1:0] plru_index;
  logic [2:0]      plru_last_access;
  logic [c_sc-1:0] hit_count, miss_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] way;
    logic [7:0] ld;
    logic       sd;
  } exp_t;
  exp_t exp_q[$];

  cache_way_ctrl #(.s_index(c_si), .s_cnt(c_sc)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .index(index),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .plru(plru), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .way_sel(way_sel),
    .load_data(load_data), .load_tag(load_tag), .data_src(data_src),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
    .plru_load(plru_load), .plru_index(plru_index), .plru_last_access(plru_last_access),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] idx,
                       input logic [7:0] hv, input logic [7:0] vv, input logic [7:0] dv,
                       input logic [2:0] pl, input logic pr);
    mem_read  = rd;  mem_write = wr; index = idx;
    hit_vec   = hv;  valid_vec = vv; dirty_vec = dv;
    plru      = pl;  pmem_resp = pr;
  endtask

  task automatic push(input logic [2:0] way, input logic [7:0] ld, input logic sd);
    exp_t e;
    e.way = way; e.ld = ld; e.sd = sd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every CPU response is matched against the next expectation.
  always @(negedge clk) begin
    if (!rst && mem_resp) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(mem_resp), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_way_sel", 32'(way_sel), 32'(e.way));
        check("sb_last_access", 32'(plru_last_access), 32'(e.way));
        check("sb_plru_load", 32'(plru_load), 32'd1);
        check("sb_load_data", 32'(load_data), 32'(e.ld));
        check("sb_set_dirty", 32'(set_dirty), 32'(e.sd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    tick(); tick();
    @(negedge clk);
    check("rst_mem_resp", 32'(mem_resp), 0);
    check("rst_pmem", 32'({pmem_read, pmem_write}), 0);
    check("rst_loads", 32'({load_data, load_tag}), 0);
    check("rst_hit_count", 32'(hit_count), 0);
    check("rst_miss_count", 32'(miss_count), 0);
    tick();
    rst = 1'b0;

    // Read hit on way 5
    drive(1, 0, 2, 8'h20, 8'hFF, 8'h00, 0, 0);
    push(5, 8'h00, 0);
    @(negedge clk);
    check("rd_hit_resp", 32'(mem_resp), 1);
    check("rd_hit_way", 32'(way_sel), 5);
    check("rd_hit_plru_index", 32'(plru_index), 2);
    check("rd_hit_pmem", 32'({pmem_read, pmem_write}), 0);
    tick();
    check("rd_hit_count", 32'(hit_count), 1);

    // Write hit on way 2
    drive(0, 1, 0, 8'h04, 8'hFF, 8'h00, 0, 0);
    push(2, 8'h04, 1);
    @(negedge clk);
    check("wr_hit_load_data", 32'(load_data), 32'h04);
    check("wr_hit_data_src", 32'(data_src), 0);
    tick();
    check("wr_hit_count", 32'(hit_count), 2);

    // Clean read miss: lowest invalid way is 3
    drive(1, 0, 1, 8'h00, 8'hF7, 8'h00, 6, 0);
    @(negedge clk);
    check("miss_no_resp", 32'(mem_resp), 0);
    tick();
    check("miss_count_1", 32'(miss_count), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fill_pmem_read", 32'(pmem_read), 1);
      check("fill_way_sel", 32'(way_sel), 3);
      check("fill_no_write", 32'({pmem_write, load_data}), 0);
      tick();
    end
    drive(1, 0, 1, 8'h00, 8'hF7, 8'h00, 6, 1);
    @(negedge clk);
    check("fill_load_data", 32'(load_data), 32'h08);
    check("fill_load_tag", 32'(load_tag), 32'h08);
    check("fill_ctl", 32'({clr_dirty, data_src, mem_resp, plru_load}), 32'b1100);
    tick();
    drive(1, 0, 1, 8'h08, 8'hFF, 8'h00, 6, 0);
    push(3, 8'h00, 0);
    @(negedge clk);
    check("recheck_resp", 32'(mem_resp), 1);
    tick();
    check("recheck_hit_count", 32'(hit_count), 3);

    // Dirty miss: all valid, plru victim 6 is dirty
    drive(1, 0, 4, 8'h00, 8'hFF, 8'h40, 6, 0);
    tick();
    check("miss_count_2", 32'(miss_count), 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wb_pmem_write", 32'({pmem_write, pmem_addr_sel, pmem_read}), 32'b110);
      check("wb_way_sel", 32'(way_sel), 6);
      tick();
    end
    drive(1, 0, 4, 8'h00, 8'hFF, 8'h40, 6, 1);
    @(negedge clk);
    check("wb_resp_no_load", 32'({load_data, load_tag}), 0);
    tick();
    drive(1, 0, 4, 8'h00, 8'hFF, 8'h40, 6, 0);
    @(negedge clk);
    check("wb_fill_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
    check("wb_fill_way", 32'(way_sel), 6);
    tick();
    drive(1, 0, 4, 8'h00, 8'hFF, 8'h40, 6, 1);
    @(negedge clk);
    check("wb_fill_load_data", 32'(load_data), 32'h40);
    tick();
    drive(1, 0, 4, 8'h40, 8'hFF, 8'h00, 6, 0);
    push(6, 8'h00, 0);
    tick();
    check("dirty_hit_count", 32'(hit_count), 4);

    // Reset while in writeback
    drive(0, 1, 1, 8'h00, 8'hFF, 8'h01, 0, 0);
    tick();
    check("miss_count_3", 32'(miss_count), 3);
    @(negedge clk);
    check("wb2_pmem_write", 32'(pmem_write), 1);
    tick();
    rst = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("rst_wb_pmem", 32'({pmem_read, pmem_write}), 0);
    check("rst_wb_updates", 32'({load_data, load_tag, mem_resp, plru_load}), 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
    check("rst_wb_counts", 32'({hit_count, miss_count}), 0);
    @(negedge clk);
    check("rst_wb_idle", 32'({pmem_read, pmem_write}), 0);
    tick();

    // Read+write together acts as a write; pmem_resp in CHECK is ignored
    drive(1, 1, 7, 8'h80, 8'hFF, 8'h00, 0, 1);
    push(7, 8'h80, 1);
    @(negedge clk);
    check("rw_ignored_resp", 32'({load_tag, clr_dirty}), 0);
    tick();
    check("rw_hit_count", 32'(hit_count), 1);

    // Saturation, with a multi-hit vector resolving to way 1
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 3, 8'h22, 8'hFF, 8'h00, 0, 0);
      push(1, 8'h00, 0);
      tick();
    end
    check("sat_hit_count_max", 32'(hit_count), 15);
    push(1, 8'h00, 0);
    tick();
    check("sat_hit_count_hold", 32'(hit_count), 15);
    drive(0, 0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
    tick();
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
